// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 requester bridge.
package apb4_master_pkg;

  localparam int         APB4_DATA_WIDTH    = 32;
  localparam logic [2:0] APB4_PPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb4_master_bridge.sv
// APB4 requester: turns a valid/ready command into one APB4 transfer and a
// valid/ready response, with misalignment and watchdog-timeout error reporting.
module apb4_master_bridge
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = APB4_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,

  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   psel_q, penable_q, psel_d, penable_d;
  logic                   pwrite_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [STRB_WIDTH-1:0]  pstrb_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic req_fire;
  logic req_aligned;
  logic timeout_hit;

  assign req_fire    = req_valid_i && (state_q == IDLE);
  assign req_aligned = (req_addr_i[1:0] == 2'b00);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // NOTE: reset is synchronous, so it lives inside the clocked block; all state
  // is updated with <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge pclk_i) begin
    if (preset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = req_aligned ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB strobes and response values are decided from the upcoming state, then registered.
  always_comb begin
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire && !req_aligned) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
        end else if (timeout_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (req_fire && req_aligned) begin
        paddr_q  <= req_addr_i;
        pwrite_q <= req_write_i;
        pwdata_q <= req_wdata_i;
        pstrb_q  <= req_write_i ? req_strb_i : '0;
      end
      // Counts ACCESS cycles without pready; wraps harmlessly when the watchdog is off.
      if (state_d == SETUP)
        cnt_q <= '0;
      else if ((state_q == ACCESS) && !pready_i && !timeout_hit)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = APB4_PPROT_DEFAULT;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: a wait-state/error-capable APB
// completer plus a transaction-level reference model of expected responses.
module tb_apb4_master_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [8] = '{default: 32'h0};
  logic [31:0] slv_mem [8] = '{default: 32'h0};
  int          acc_cnt = 0;
  int          wait_cfg = 0;
  bit          err_cfg = 1'b0;

  always #5 clk = ~clk;

  apb4_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i(clk), .preset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // Completer: ready after wait_cfg ACCESS cycles; drives junk outside ACCESS.
  assign pready  = (psel && penable) ? (acc_cnt == wait_cfg) : 1'b1;
  assign pslverr = (psel && penable) ? (pready && err_cfg) : 1'b1;
  assign prdata  = err_cfg ? 32'hDEAD_BEEF : slv_mem[paddr[4:2]];

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !err_cfg)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) slv_mem[paddr[4:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  // One complete request/response; expectations come from the transfer rules.
  task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int wait_n, input bit err_n, input int rsp_delay);
    bit          mis, tout, exp_err;
    int          exp_lat, exp_pen, cycle, pen_cnt, pen_first, psel_cnt, viol;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pstrb;
    mis       = (addr[1:0] != 2'b00);
    tout      = !mis && (wait_n >= TO);
    exp_err   = mis || tout || err_n;
    exp_rdata = (!wr && !exp_err) ? ref_mem[addr[4:2]] : 32'h0;
    exp_lat   = mis ? 1 : (tout ? 2 + TO : 3 + wait_n);
    exp_pen   = mis ? 0 : (tout ? TO : wait_n + 1);
    exp_pstrb = wr ? strb : 4'h0;
    if (wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
    wait_cfg = wait_n;
    err_cfg  = err_n;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = (rsp_delay == 0);
    cycle = 1; pen_cnt = 0; pen_first = 0; psel_cnt = 0; viol = 0;
    while (rsp_valid !== 1'b1 && cycle < 64) begin
      if (psel === 1'b1) psel_cnt++;
      if (penable === 1'b1) begin
        pen_cnt++;
        if (pen_first == 0) pen_first = cycle;
        if (psel !== 1'b1) viol++;
      end
      if (psel === 1'b1 && (paddr !== addr || pwrite !== wr || pstrb !== exp_pstrb ||
                            (wr && pwdata !== wdata) || pprot !== 3'b000)) viol++;
      @(posedge clk); #1;
      cycle++;
    end

    checks++;
    if (rsp_valid !== 1'b1 || cycle != exp_lat) begin
      errors++; $display("FAIL %s latency: got cycle %0d valid %b want cycle %0d", name, cycle, rsp_valid, exp_lat);
    end
    checks++;
    if (psel_cnt != exp_pen + (mis ? 0 : 1)) begin
      errors++; $display("FAIL %s psel_cycles: got %0d want %0d", name, psel_cnt, exp_pen + (mis ? 0 : 1));
    end
    checks++;
    if (pen_cnt != exp_pen) begin
      errors++; $display("FAIL %s penable_cycles: got %0d want %0d", name, pen_cnt, exp_pen);
    end
    if (!mis) begin
      checks++;
      if (pen_first != 2) begin
        errors++; $display("FAIL %s penable_first: got cycle %0d want 2", name, pen_first);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL %s apb_stable: got %0d bad cycles want 0", name, viol);
    end
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      errors++; $display("FAIL %s resp_idle_bus: got psel %b penable %b want 0 0", name, psel, penable);
    end
    checks++;
    if (rsp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, exp_rdata);
    end
    checks++;
    if (rsp_err !== exp_err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, rsp_err, exp_err);
    end
    repeat (rsp_delay) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
        errors++; $display("FAIL %s hold: got valid %b rdata %h err %b want 1 %h %b",
                           name, rsp_valid, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s return_idle: got ready %b valid %b want 1 0", name, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 ||
        paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got ctl %b paddr %h pwdata %h pstrb %h rdata %h want all 0",
                         {psel, penable, pwrite, rsp_valid, rsp_err}, paddr, pwdata, pstrb, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1 || pprot !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got ready %b pprot %b want 1 000", req_ready, pprot);
    end
    rst = 1'b0;
  endtask

  task automatic test_gpio_write();
    do_txn("gpio_write", 1'b1, 32'h08, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 0);
    checks++;
    if (slv_mem[2] !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL gpio_out: got %h want a5a50f0f", slv_mem[2]);
    end
  endtask

  task automatic test_read_back();
    do_txn("read_back", 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, 0);
  endtask

  task automatic test_wait_states();
    do_txn("wait_states", 1'b0, 32'h08, 32'h0, 4'h0, 3, 1'b0, 1);
  endtask

  task automatic test_slverr();
    do_txn("slverr_read", 1'b0, 32'h08, 32'h0, 4'h0, 1, 1'b1, 0);
    do_txn("slverr_write", 1'b1, 32'h08, 32'h1234_5678, 4'hF, 0, 1'b1, 0);
  endtask

  task automatic test_timeout();
    do_txn("timeout_abort", 1'b1, 32'h0C, 32'h5555_AAAA, 4'hF, 1000, 1'b0, 0);
    do_txn("timeout_edge_ready", 1'b1, 32'h0C, 32'h1357_9BDF, 4'hF, TO - 1, 1'b0, 0);
    do_txn("timeout_readback", 1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0, 0);
  endtask

  task automatic test_misaligned();
    do_txn("misaligned", 1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_transfer();
    wait_cfg = 1000; err_cfg = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFE_F00D; req_strb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++; $display("FAIL rst_mid_access: got psel %b penable %b want 1 1", psel, penable);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got psel %b pen %b ready %b valid %b err %b want 0 0 1 0 0",
                         psel, penable, req_ready, rsp_valid, rsp_err);
    end
    do_txn("after_reset", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn("back_to_back", i[0], {27'h0, i[2:0] + 3'd4, 2'b00}, 32'h0101_0101 * (i + 1), 4'hF, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [2:0]  idx;
      logic [1:0]  lo;
      int          r, wait_n;
      wr  = 1'($urandom_range(0, 1));
      idx = 3'($urandom_range(0, 7));
      lo  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r   = $urandom_range(0, 19);
      wait_n = (r < 15) ? (r % 4) : ((r < 18) ? TO - 1 : TO + 2);
      do_txn("random", wr, {27'h0, idx, lo}, $urandom, 4'($urandom_range(0, 15)), wait_n,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_gpio_write();
    test_read_back();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_misaligned();
    test_reset_mid_transfer();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
